sync_fifo_bram: RTL and testbench
=================================

SYNC_FIFO_BRAM -- requirements
Module: sync_fifo_bram

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, number of storage locations; power of two, >= 4.
REQ-002 The module SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-003 The module SHALL have port i_clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_write, input, 1 bit: push request.
REQ-006 The module SHALL have port i_wdata, input, WIDTH bits: push data.
REQ-007 The module SHALL have port i_read, input, 1 bit: pop request.
REQ-008 The module SHALL have port o_rdata, output, WIDTH bits: popped or head data.
REQ-009 The module SHALL have port o_empty, output, 1 bit: high when occupancy is 0.
REQ-010 The module SHALL have port o_full, output, 1 bit: high when occupancy is DEPTH-1.
REQ-011 The module SHALL have port o_queued, output, $clog2(DEPTH) bits: current occupancy.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH array, inferable as block RAM, with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-013 Capacity SHALL be DEPTH-1 entries (one slot always unused), so o_queued never exceeds DEPTH-1 and always fits its width.
REQ-014 A push SHALL be accepted on a rising edge when i_write=1 and o_full=0 (flag value before the edge); i_wdata goes to mem[wr_ptr] and wr_ptr increments.
REQ-015 A pop SHALL be accepted on a rising edge when i_read=1 and o_empty=0 (flag value before the edge); rd_ptr increments.
REQ-016 A push while full SHALL be dropped, with no state change; a pop while empty SHALL be ignored, with o_rdata unchanged.
REQ-017 A simultaneous accepted push and pop SHALL leave o_queued unchanged; when empty, only the push is accepted (no bypass); when full, only the pop is accepted.
REQ-018 o_queued, o_empty and o_full SHALL be registered and SHALL reflect the new occupancy in the cycle after the accepting edge.
REQ-019 o_queued SHALL equal (wr_ptr - rd_ptr) modulo DEPTH at all times.
REQ-020 Data SHALL exit in the same order it entered; no entry is lost or duplicated across pointer wrap-around.

Reset
REQ-021 While i_reset=0, independent of i_clock: pointers and o_queued SHALL be 0, o_empty=1, o_full=0, o_rdata=0.
REQ-022 Memory contents SHALL NOT be cleared by reset.
REQ-023 Reset asserted mid-operation SHALL discard all queued entries immediately; the first edge after release behaves as REQ-014/REQ-015 on an empty FIFO.

Configuration
REQ-024 Macro FIFO_BRAM_FWFT_EN SHALL select the read mode.
REQ-025 Without FIFO_BRAM_FWFT_EN, reads SHALL be registered: on an accepted pop edge o_rdata loads mem[rd_ptr] (1-cycle latency), and o_rdata holds its value otherwise.
REQ-026 With FIFO_BRAM_FWFT_EN, o_rdata SHALL show mem[rd_ptr] combinationally whenever o_empty=0 and SHALL be 0 when o_empty=1; a pop advances to the next entry in the following cycle.

Verification (DEPTH=16, WIDTH=32)
REQ-027 Reset, then idle -> o_empty=1, o_full=0, o_queued=0, o_rdata=0.
REQ-028 Push 0x1111_0001..0x1111_000F (15 words) -> o_full=1 and o_queued=15; a 16th push of 0xDEAD_BEEF is dropped.
REQ-029 From full, pop 15 times -> o_rdata sequence 0x1111_0001..0x1111_000F in order, then o_empty=1; a 16th pop leaves o_rdata=0x1111_000F.
REQ-030 Run 40 pushes interleaved with pops, holding occupancy at 3 across pointer wrap -> in-order data, o_queued=3 throughout.
REQ-031 Push and pop in the same cycle at occupancy 5 -> o_queued stays 5; on an empty FIFO -> o_queued becomes 1 and o_rdata is unchanged.
REQ-032 Assert reset asynchronously with 7 entries queued -> flags are immediately empty/0 without waiting for a clock edge; the next push/pop returns the new data.

Source files
------------

// File: rtl/sync_fifo_bram.sv
// Single-clock FIFO on a block-RAM array, DEPTH-1 usable entries.
// Define FIFO_BRAM_FWFT_EN for first-word-fall-through reads.
module sync_fifo_bram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_write,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH)-1:0] o_queued
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_queued;
  logic             r_empty;
  logic             r_full;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_queued_nxt;

  assign w_push = i_write & ~r_full;
  assign w_pop  = i_read & ~r_empty;

  always_comb begin
    w_queued_nxt = r_queued;
    unique case ({w_push, w_pop})
      2'b10:   w_queued_nxt = r_queued + AW'(1);
      2'b01:   w_queued_nxt = r_queued - AW'(1);
      default: w_queued_nxt = r_queued;
    endcase
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge i_clock) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_queued <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_queued <= w_queued_nxt;
      r_empty  <= (w_queued_nxt == '0);
      r_full   <= (w_queued_nxt == AW'(DEPTH - 1));
    end
  end

`ifdef FIFO_BRAM_FWFT_EN
  assign o_rdata = r_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      r_rdata <= '0;
    else if (w_pop)
      r_rdata <= r_mem[r_rd_ptr];
  end

  assign o_rdata = r_rdata;
`endif

  assign o_empty  = r_empty;
  assign o_full   = r_full;
  assign o_queued = r_queued;
endmodule

// File: tb/tb_sync_fifo_bram.sv
// Directed self-checking bench for sync_fifo_bram (registered-read build).
module tb_sync_fifo_bram;
  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] rdata;
  logic        empty;
  logic        full;
  logic [3:0]  queued;

  int n_chk;
  int n_err;

  sync_fifo_bram #(
    .DEPTH(16),
    .WIDTH(32)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_write (wr),
    .i_wdata (wdata),
    .i_read  (rd),
    .o_rdata (rdata),
    .o_empty (empty),
    .o_full  (full),
    .o_queued(queued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic w,
                      input logic [31:0] d,
                      input logic r);
    @(negedge clk);
    wr    = w;
    wdata = d;
    rd    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag,
                       input logic e,
                       input logic f,
                       input logic [3:0] q);
    chk({tag, "_empty"}, 32'(empty), 32'(e));
    chk({tag, "_full"}, 32'(full), 32'(f));
    chk({tag, "_queued"}, 32'(queued), 32'(q));
  endtask

  logic [31:0] last;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    flags("rst", 1'b1, 1'b0, 4'd0);
    chk("rst_rdata", rdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    flags("idle", 1'b1, 1'b0, 4'd0);

    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 32'h1111_0000 + 32'(i), 1'b0);
      chk("fill_q", 32'(queued), 32'(i));
    end
    flags("full", 1'b0, 1'b1, 4'd15);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    flags("drop", 1'b0, 1'b1, 4'd15);

    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("drain_d", rdata, 32'h1111_0000 + 32'(i));
    end
    flags("drained", 1'b1, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("pop_empty_d", rdata, 32'h1111_000F);
    flags("pop_empty", 1'b1, 1'b0, 4'd0);

    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h2222_0000 + 32'(k), 1'b0);
    chk("ilv_pre_q", 32'(queued), 32'd3);
    for (int k = 3; k < 40; k++) begin
      step(1'b1, 32'h2222_0000 + 32'(k), 1'b1);
      chk("ilv_d", rdata, 32'h2222_0000 + 32'(k - 3));
      chk("ilv_q", 32'(queued), 32'd3);
    end
    for (int k = 37; k < 40; k++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("ilv_tail", rdata, 32'h2222_0000 + 32'(k));
    end
    flags("ilv_end", 1'b1, 1'b0, 4'd0);

    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h3333_0000 + 32'(k), 1'b0);
    chk("occ5_q", 32'(queued), 32'd5);
    step(1'b1, 32'h3333_0005, 1'b1);
    chk("both5_q", 32'(queued), 32'd5);
    chk("both5_d", rdata, 32'h3333_0000);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("both5_drain", rdata, 32'h3333_0000 + 32'(k));
    end
    flags("both5_end", 1'b1, 1'b0, 4'd0);

    last = 32'h3333_0005;
    step(1'b1, 32'h4444_0001, 1'b1);
    chk("both0_q", 32'(queued), 32'd1);
    chk("both0_d", rdata, last);
    chk("both0_empty", 32'(empty), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("both0_pop", rdata, 32'h4444_0001);

    for (int k = 0; k < 7; k++)
      step(1'b1, 32'h5555_0000 + 32'(k), 1'b0);
    chk("pre_rst_q", 32'(queued), 32'd7);
    wr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    flags("arst", 1'b1, 1'b0, 4'd0);
    chk("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hCAFE_0001, 1'b0);
    flags("post_push", 1'b0, 1'b0, 4'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("post_pop_d", rdata, 32'hCAFE_0001);
    flags("post_pop", 1'b1, 1'b0, 4'd0);
    step(1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
